// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program sequencer state encoding and default PC width.
package cpu_pkg;

    localparam int PC_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_EXEC  = 2'd1,
        SEQ_FAULT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/return_stack.sv
// Parameterised LIFO of return addresses. A synchronous active-high rst clears only the pointer;
// entry contents are left as they are.
module return_stack #(
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 8,
    localparam int SP_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    push_data,
    output logic [WIDTH-1:0]    top,
    output logic [SP_WIDTH-1:0] depth,
    output logic                full,
    output logic                empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [SP_WIDTH-1:0] depth_q;

    assign full  = (depth_q == SP_WIDTH'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign top   = mem_q[AW'(depth_q - 1'b1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop && !empty) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[AW'(depth_q)] <= push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter, call/return stack and fetch/execute sequencing.
// Optional STACK_TRAP_EN: stack overflow/underflow traps into a sticky FAULT state.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int  PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int  STACK_DEPTH = 8,
    localparam int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_ack,
    input  logic                jmp,
    input  logic                cal_f,
    input  logic                ret_f,
    input  logic                rst_f,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    output logic                rom_req,
    output logic [PC_WIDTH-1:0] rom_addr,
    output logic                exec_en,
    output logic [SP_WIDTH-1:0] stack_depth,
    output logic                fault
);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                rom_req_q, rom_req_d;
    logic                exec_en_q, exec_en_d;
    logic                stk_push, stk_pop, stk_clr, stk_rst;
    logic                stk_full, stk_empty;
    logic [PC_WIDTH-1:0] stk_top;
    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign stk_rst = rst || stk_clr;

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (stk_rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .depth     (stack_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

`ifdef STACK_TRAP_EN
    logic fault_q, fault_d;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rom_req_d = 1'b0;
        exec_en_d = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clr   = 1'b0;
`ifdef STACK_TRAP_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            SEQ_FETCH: begin
                // Only an ack seen while our request is visible counts as the fetch completing.
                if (rom_req_q && rom_ack) begin
                    state_d   = SEQ_EXEC;
                    exec_en_d = 1'b1;
                end else begin
                    rom_req_d = 1'b1;
                end
            end
            SEQ_EXEC: begin
                state_d   = SEQ_FETCH;
                rom_req_d = 1'b1;
                if (!rst_f) begin
                    pc_d    = '0;
                    stk_clr = 1'b1;
                end else if (cal_f) begin
                    if (stk_full) begin
`ifdef STACK_TRAP_EN
                        state_d   = SEQ_FAULT;
                        rom_req_d = 1'b0;
                        fault_d   = 1'b1;
`else
                        pc_d = jmp_addr;
`endif
                    end else begin
                        stk_push = 1'b1;
                        pc_d     = jmp_addr;
                    end
                end else if (ret_f) begin
                    if (stk_empty) begin
`ifdef STACK_TRAP_EN
                        state_d   = SEQ_FAULT;
                        rom_req_d = 1'b0;
                        fault_d   = 1'b1;
`else
                        pc_d = '0;
`endif
                    end else begin
                        stk_pop = 1'b1;
                        pc_d    = stk_top;
                    end
                end else if (jmp) begin
                    pc_d = jmp_addr;
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                // FAULT (or an unreachable code) holds until rst.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_FETCH;
            pc_q      <= '0;
            rom_req_q <= 1'b0;
            exec_en_q <= 1'b0;
`ifdef STACK_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rom_req_q <= rom_req_d;
            exec_en_q <= exec_en_d;
`ifdef STACK_TRAP_EN
            fault_q   <= fault_d;
`endif
        end
    end

    assign rom_req  = rom_req_q;
    assign rom_addr = pc_q;
    assign exec_en  = exec_en_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized instruction
// streams against a queue-based model of the PC and return stack.
module tb_program_sequencer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rom_ack;
    logic       jmp, cal_f, ret_f, rst_f;
    logic [7:0] jmp_addr;
    logic       rom_req;
    logic [7:0] rom_addr;
    logic       exec_en;
    logic [3:0] stack_depth;
    logic       fault;

    int n_checks = 0;
    int n_fail   = 0;

    int m_pc;
    int m_stk[$];
    bit m_fault;

    program_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ack     (rom_ack),
        .jmp         (jmp),
        .cal_f       (cal_f),
        .ret_f       (ret_f),
        .rst_f       (rst_f),
        .jmp_addr    (jmp_addr),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .exec_en     (exec_en),
        .stack_depth (stack_depth),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_flags();
        cal_f    = 1'b0;
        ret_f    = 1'b0;
        jmp      = 1'b0;
        rst_f    = 1'b1;
        jmp_addr = 8'($urandom);
    endtask

    task automatic model_step(input bit c, input bit r, input bit j, input bit rf, input int a);
        if (!rf) begin
            m_pc = 0;
            m_stk.delete();
        end else if (c) begin
            if (m_stk.size() == DEPTH) begin
`ifdef STACK_TRAP_EN
                m_fault = 1'b1;
`else
                m_pc = a;
`endif
            end else begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = a;
            end
        end else if (r) begin
            if (m_stk.size() == 0) begin
`ifdef STACK_TRAP_EN
                m_fault = 1'b1;
`else
                m_pc = 0;
`endif
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (j) begin
            m_pc = a;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    // Entered at a negedge with rst possibly high or low; leaves at the negedge of the first
    // FETCH cycle with rom_req visible.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        rom_ack = 1'($urandom_range(0, 1));
        idle_flags();
        @(negedge clk);
        chk("rst_req",   32'(rom_req), 0);
        chk("rst_pc",    32'(rom_addr), 0);
        chk("rst_exec",  32'(exec_en), 0);
        chk("rst_depth", 32'(stack_depth), 0);
        chk("rst_fault", 32'(fault), 0);
        m_pc    = 0;
        m_fault = 1'b0;
        m_stk.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req",  32'(rom_req), 1);
        chk("rel_pc",   32'(rom_addr), 0);
        chk("rel_exec", 32'(exec_en), 0);
    endtask

    // Entered at the negedge of a FETCH cycle with rom_req high.
    task automatic do_instr(input bit c, input bit r, input bit j, input bit rf,
                            input logic [7:0] a, input int dly);
        chk("fetch_req",   32'(rom_req), 1);
        chk("fetch_pc",    32'(rom_addr), m_pc);
        chk("fetch_exec",  32'(exec_en), 0);
        chk("fetch_depth", 32'(stack_depth), m_stk.size());
        for (int i = 0; i < dly; i++) begin
            rom_ack = 1'b0;
            @(negedge clk);
            chk("wait_req",  32'(rom_req), 1);
            chk("wait_pc",   32'(rom_addr), m_pc);
            chk("wait_exec", 32'(exec_en), 0);
        end
        rom_ack = 1'b1;
        @(negedge clk);
        chk("exec_en",  32'(exec_en), 1);
        chk("exec_req", 32'(rom_req), 0);
        chk("exec_pc",  32'(rom_addr), m_pc);
        cal_f    = c;
        ret_f    = r;
        jmp      = j;
        rst_f    = rf;
        jmp_addr = a;
        rom_ack  = 1'($urandom_range(0, 1));
        @(negedge clk);
        model_step(c, r, j, rf, 32'(a));
        idle_flags();
        rom_ack = 1'b0;
        chk("next_pc",    32'(rom_addr), m_pc);
        chk("next_depth", 32'(stack_depth), m_stk.size());
        chk("next_fault", 32'(fault), 32'(m_fault));
        chk("next_req",   32'(rom_req), 32'(!m_fault));
        chk("next_exec",  32'(exec_en), 0);
    endtask

    task automatic fault_hold();
        for (int i = 0; i < 3; i++) begin
            rom_ack  = 1'($urandom_range(0, 1));
            cal_f    = 1'($urandom_range(0, 1));
            ret_f    = 1'($urandom_range(0, 1));
            jmp      = 1'($urandom_range(0, 1));
            jmp_addr = 8'($urandom);
            @(negedge clk);
            chk("hold_fault", 32'(fault), 1);
            chk("hold_req",   32'(rom_req), 0);
            chk("hold_exec",  32'(exec_en), 0);
            chk("hold_pc",    32'(rom_addr), m_pc);
            chk("hold_depth", 32'(stack_depth), m_stk.size());
        end
        idle_flags();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rom_ack = 1'b0;
        idle_flags();
        m_pc    = 0;
        m_fault = 1'b0;

        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 1, 8'h00, 0);
        chk("seq_pc_3", 32'(rom_addr), 3);

        do_instr(0, 0, 0, 1, 8'h00, 3);

        do_instr(0, 0, 1, 1, 8'h10, 0);
        do_instr(1, 0, 1, 1, 8'h80, 0);
        chk("call_pc", 32'(rom_addr), 32'h80);
        do_instr(0, 1, 1, 1, 8'h00, 0);
        chk("ret_pc", 32'(rom_addr), 32'h11);

        for (int i = 0; i < 9; i++) do_instr(1, 0, 1, 1, 8'(8'h20 + i), 0);
        chk("ovf_depth", 32'(stack_depth), DEPTH);
        if (m_fault) begin
            fault_hold();
            do_reset();
        end else begin
            for (int i = 0; i < DEPTH; i++) do_instr(0, 1, 1, 1, 8'h00, 0);
        end

        for (int i = 0; i < 3; i++) do_instr(1, 0, 1, 1, 8'(8'h40 + 4 * i), 0);
        do_instr(0, 0, 0, 0, 8'h55, 0);
        chk("softrst_pc", 32'(rom_addr), 0);
        chk("softrst_depth", 32'(stack_depth), 0);

        do_instr(0, 0, 1, 1, 8'hFF, 0);
        do_instr(0, 0, 0, 1, 8'h00, 0);
        chk("wrap_pc", 32'(rom_addr), 0);
        do_instr(0, 0, 1, 1, 8'hFF, 0);
        do_instr(1, 0, 1, 1, 8'h30, 0);
        do_instr(0, 1, 1, 1, 8'h00, 0);
        do_instr(1, 1, 1, 1, 8'h77, 1);

        do_instr(0, 0, 1, 1, 8'h5A, 0);
        rom_ack = 1'b0;
        do_reset();

        do_instr(0, 1, 1, 1, 8'h00, 0);
        if (m_fault) begin
            fault_hold();
            do_reset();
        end

        for (int n = 0; n < 400; n++) begin
            if (m_fault) begin
                fault_hold();
                do_reset();
            end else if ($urandom_range(0, 49) == 0) begin
                rom_ack = 1'b0;
                do_reset();
            end
            do_instr(1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 15) != 0),
                     8'($urandom),
                     $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
